mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, giving the address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, giving the maximum cycles to wait for an ack before aborting, legal range 1..255.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset: port i_clk, input, 1, clock, with all state updated on its rising edge.
REQ-005 i_rst  input  1  synchronous active-high reset.
REQ-006 i_if_req  input  1  fetch-stage request; held high until o_if_valid.
REQ-007 i_if_addr  input  ADDR_W  fetch address.
REQ-008 i_dm_req  input  1  mem-stage request; held high until o_dm_valid.
REQ-009 i_dm_we  input  1  mem-stage write (1) or read (0).
REQ-010 i_dm_addr / i_dm_wdata / i_dm_be  input  ADDR_W / DATA_W / DATA_W/8  data access address, write data, byte enables.
REQ-011 o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be  output  1/1/ADDR_W/DATA_W/DATA_W/8  registered request to the shared memory port.
REQ-012 i_mem_ack  input  1  memory completion, sampled only while o_mem_req=1.
REQ-013 i_mem_rdata  input  DATA_W  memory read data, valid with i_mem_ack.
REQ-014 o_if_data / o_if_valid, o_dm_rdata / o_dm_valid  output  DATA_W / 1  returned data and one-cycle completion pulse per requester.
REQ-015 o_if_stall, o_dm_stall  output  1  pipeline stall to the fetch and mem stages.
REQ-016 o_err  output  1  one-cycle pulse on access timeout.

Function
REQ-017 The FSM SHALL have states IDLE, IF_BUSY and DM_BUSY.
REQ-018 In IDLE, i_dm_req=1 SHALL grant DM (data has fixed priority over fetch); otherwise i_if_req=1 SHALL grant IF; otherwise the FSM SHALL stay in IDLE.
REQ-019 On grant, the block SHALL capture the granted address, we, wdata and be into the o_mem_* registers, set o_mem_req=1 on the next cycle and enter the matching BUSY state.
REQ-020 An IF grant SHALL force o_mem_we=0 and o_mem_be to all ones.
REQ-021 While in BUSY, o_mem_* SHALL be held stable and requester inputs SHALL be ignored.
REQ-022 On i_mem_ack=1 in BUSY, the block SHALL register i_mem_rdata into the owner's data output and pulse the owner's valid for exactly one cycle.
REQ-023 In the same ack cycle, the block SHALL clear o_mem_req and return to IDLE.
REQ-024 A DM write SHALL also pulse o_dm_valid on ack; o_dm_rdata then takes i_mem_rdata unchanged.
REQ-025 Latency: a grant in cycle N SHALL give o_mem_req=1 in N+1; an ack in cycle M SHALL give valid in M+1; the minimum round trip is therefore 2 cycles.
REQ-026 In the cycle its valid is high, a requester's req SHALL be masked from arbitration, so there is no double grant.
REQ-027 If both requests are pending, back-to-back service SHALL be possible: DM valid and IF grant occur in the same IDLE cycle.
REQ-028 A watchdog counter of 8 bits SHALL clear on grant and increment each BUSY cycle without ack.
REQ-029 When the watchdog reaches TIMEOUT, the block SHALL clear o_mem_req, pulse o_err, pulse the owner's valid with data 0, and return to IDLE.
REQ-030 An ack in the same cycle as the timeout SHALL win: normal completion, no o_err.
REQ-031 o_if_stall SHALL equal i_if_req & ~o_if_valid, and o_dm_stall SHALL equal i_dm_req & ~o_dm_valid (combinational).
REQ-032 The valid pulses SHALL be mutually exclusive.
REQ-033 o_mem_req SHALL never be asserted for two consecutive accesses without at least one IDLE cycle between them.

Reset
REQ-034 i_rst=1 SHALL force, at the next edge, state IDLE, o_mem_req=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_mem_be=0, o_if_data=0, o_dm_rdata=0, o_if_valid=0, o_dm_valid=0, o_err=0, and watchdog=0.
REQ-035 Reset during BUSY SHALL abandon the access with no valid pulse; an ack arriving in or after the reset cycle SHALL be ignored.

Verification
REQ-036 IF only: if_req=1, addr=0x100, ack 3 cycles after o_mem_req with rdata=0x00000013 -> o_mem_addr=0x100, we=0, be=0xF; o_if_valid pulses once with o_if_data=0x13; o_if_stall=1 until then.
REQ-037 Simultaneous requests: if_req and dm_req both 1, dm read addr=0x2000, immediate acks -> DM served first, then IF granted in DM's valid cycle; the order on o_mem_addr is 0x2000 then the IF address.
REQ-038 DM write: we=1, addr=0x40, wdata=0xDEADBEEF, be=0x3 -> o_mem_* carry those exact values, o_dm_valid pulses once, and no IF valid occurs.
REQ-039 Timeout: TIMEOUT=4 with no ack -> o_mem_req drops after 4 BUSY cycles, o_err=1 for one cycle, owner valid pulses with data 0, and a new grant is possible next.
REQ-040 Reset mid-access: i_rst in the second BUSY cycle, then ack -> o_mem_req=0, no valid, no o_err, and state IDLE.
REQ-041 Ack coincident with timeout -> valid pulses with rdata and o_err stays 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter: data-stage requests take fixed priority over fetch,
// one access in flight at a time, with an 8-bit watchdog that aborts stuck accesses.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_if_req,
    input  logic [ADDR_W-1:0]   i_if_addr,
    input  logic                i_dm_req,
    input  logic                i_dm_we,
    input  logic [ADDR_W-1:0]   i_dm_addr,
    input  logic [DATA_W-1:0]   i_dm_wdata,
    input  logic [DATA_W/8-1:0] i_dm_be,
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_be,
    input  logic                i_mem_ack,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    output logic [DATA_W-1:0]   o_if_data,
    output logic                o_if_valid,
    output logic [DATA_W-1:0]   o_dm_rdata,
    output logic                o_dm_valid,
    output logic                o_if_stall,
    output logic                o_dm_stall,
    output logic                o_err
);

    localparam logic [7:0] WDOG_LIMIT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        IF_BUSY,
        DM_BUSY
    } state_t;

    state_t     state, state_n;
    logic [7:0] wdog;
    logic [7:0] wdog_inc;
    logic       grant_dm, grant_if, ack_done, timeout;

    assign wdog_inc = wdog + 8'd1;

    // A requester whose valid is high this cycle is masked so it is not granted twice.
    always_comb begin
        state_n  = state;
        grant_dm = 1'b0;
        grant_if = 1'b0;
        ack_done = 1'b0;
        timeout  = 1'b0;
        case (state)
            IDLE: begin
                if (i_dm_req && !o_dm_valid) begin
                    grant_dm = 1'b1;
                    state_n  = DM_BUSY;
                end else if (i_if_req && !o_if_valid) begin
                    grant_if = 1'b1;
                    state_n  = IF_BUSY;
                end
            end
            IF_BUSY, DM_BUSY: begin
                if (i_mem_ack && o_mem_req) begin
                    ack_done = 1'b1;
                    state_n  = IDLE;
                end else if (wdog_inc == WDOG_LIMIT) begin
                    timeout  = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_be    <= '0;
            o_if_data   <= '0;
            o_dm_rdata  <= '0;
            o_if_valid  <= 1'b0;
            o_dm_valid  <= 1'b0;
            o_err       <= 1'b0;
            wdog        <= '0;
        end else begin
            o_if_valid <= 1'b0;
            o_dm_valid <= 1'b0;
            o_err      <= 1'b0;
            if (grant_dm) begin
                o_mem_req   <= 1'b1;
                o_mem_we    <= i_dm_we;
                o_mem_addr  <= i_dm_addr;
                o_mem_wdata <= i_dm_wdata;
                o_mem_be    <= i_dm_be;
                wdog        <= '0;
            end else if (grant_if) begin
                o_mem_req   <= 1'b1;
                o_mem_we    <= 1'b0;
                o_mem_addr  <= i_if_addr;
                o_mem_wdata <= '0;
                o_mem_be    <= '1;
                wdog        <= '0;
            end else if (ack_done || timeout) begin
                // An aborted access still completes towards its owner, with zero data.
                o_mem_req <= 1'b0;
                o_err     <= timeout;
                if (state == DM_BUSY) begin
                    o_dm_valid <= 1'b1;
                    o_dm_rdata <= ack_done ? i_mem_rdata : '0;
                end else begin
                    o_if_valid <= 1'b1;
                    o_if_data  <= ack_done ? i_mem_rdata : '0;
                end
            end else if (state != IDLE) begin
                wdog <= wdog_inc;
            end
        end
    end

    assign o_if_stall = i_if_req & ~o_if_valid;
    assign o_dm_stall = i_dm_req & ~o_dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level model predicts each memory
// access and each completion (owner, data, error, cycle) from the arbitration rules.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int TO = 4;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_if_req;
    logic [AW-1:0] i_if_addr;
    logic          i_dm_req;
    logic          i_dm_we;
    logic [AW-1:0] i_dm_addr;
    logic [DW-1:0] i_dm_wdata;
    logic [BW-1:0] i_dm_be;
    logic          o_mem_req;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic [BW-1:0] o_mem_be;
    logic          i_mem_ack;
    logic [DW-1:0] i_mem_rdata;
    logic [DW-1:0] o_if_data;
    logic          o_if_valid;
    logic [DW-1:0] o_dm_rdata;
    logic          o_dm_valid;
    logic          o_if_stall;
    logic          o_dm_stall;
    logic          o_err;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr),
        .i_dm_req(i_dm_req), .i_dm_we(i_dm_we), .i_dm_addr(i_dm_addr),
        .i_dm_wdata(i_dm_wdata), .i_dm_be(i_dm_be),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
        .o_if_data(o_if_data), .o_if_valid(o_if_valid),
        .o_dm_rdata(o_dm_rdata), .o_dm_valid(o_dm_valid),
        .o_if_stall(o_if_stall), .o_dm_stall(o_dm_stall), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    int unsigned cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        logic          dm;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
        int unsigned   lat;
        logic [DW-1:0] rdata;
        int unsigned   rise;
    } access_t;

    typedef struct {
        logic          dm;
        logic [DW-1:0] data;
        logic          err;
        int unsigned   at;
    } done_t;

    access_t mem_q[$];
    done_t   done_q[$];

    int unsigned checks = 0;
    int unsigned passed = 0;
    bit          resp_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Memory responder: acks each access in its planned BUSY cycle (never, for planned timeouts).
    initial begin
        access_t     a;
        int unsigned k;
        i_mem_ack   = 1'b0;
        i_mem_rdata = '0;
        forever begin
            @(negedge i_clk);
            if (resp_en) begin
                i_mem_ack   = 1'b0;
                i_mem_rdata = $urandom;
                if (o_mem_req) begin
                    if (mem_q.size() == 0) begin
                        check("unexpected_mem_req", o_mem_req, 0);
                    end else begin
                        a = mem_q.pop_front();
                        check("req_cycle", cyc, a.rise);
                        check("mem_we", o_mem_we, a.we);
                        check("mem_addr", o_mem_addr, a.addr);
                        check("mem_be", o_mem_be, a.be);
                        if (a.dm) check("mem_wdata", o_mem_wdata, a.wdata);
                        k = 1;
                        forever begin
                            if (k == a.lat) begin
                                i_mem_ack   = 1'b1;
                                i_mem_rdata = a.rdata;
                            end
                            @(negedge i_clk);
                            i_mem_ack   = 1'b0;
                            i_mem_rdata = $urandom;
                            if (k == a.lat) begin
                                check("req_clear_after_ack", o_mem_req, 0);
                                break;
                            end
                            if (!o_mem_req) begin
                                check("timeout_busy_len", k, TO);
                                break;
                            end
                            if (k > TO + 2) begin
                                check("req_bounded", o_mem_req, 0);
                                break;
                            end
                            check("mem_addr_hold", o_mem_addr, a.addr);
                            k++;
                        end
                    end
                end
            end
        end
    end

    // Completion monitor.
    initial begin
        done_t d;
        forever begin
            @(negedge i_clk);
            if (o_if_valid || o_dm_valid || o_err) begin
                if (done_q.size() == 0) begin
                    check("unexpected_completion", {o_dm_valid, o_if_valid, o_err}, 0);
                end else begin
                    d = done_q.pop_front();
                    check("valid_owner", {o_dm_valid, o_if_valid}, d.dm ? 2'b10 : 2'b01);
                    check("valid_cycle", cyc, d.at);
                    check("valid_data", d.dm ? o_dm_rdata : o_if_data, d.data);
                    check("err_pulse", o_err, d.err);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge i_clk);
            #2;
            check("if_stall", o_if_stall, i_if_req & ~o_if_valid);
            check("dm_stall", o_dm_stall, i_dm_req & ~o_dm_valid);
        end
    end

    // Predicts the whole round: DM goes first when both are pending, each completion
    // lands min(lat, TO) cycles after its request rises, the next request one cycle later.
    task automatic run_round(input bit do_if, input bit do_dm, input bit we,
                             input logic [AW-1:0] if_addr, input logic [AW-1:0] dm_addr,
                             input logic [DW-1:0] wdata, input logic [BW-1:0] be,
                             input int unsigned lat_if, input int unsigned lat_dm,
                             input logic [DW-1:0] rd_if, input logic [DW-1:0] rd_dm);
        int unsigned t;
        int unsigned done_at;
        access_t a;
        done_t d;
        t = cyc + 1;
        if (do_dm) begin
            a = '{dm: 1'b1, we: we, addr: dm_addr, wdata: wdata, be: be,
                  lat: lat_dm, rdata: rd_dm, rise: t};
            mem_q.push_back(a);
            done_at = t + ((lat_dm <= TO) ? lat_dm : TO);
            d = '{dm: 1'b1, data: (lat_dm <= TO) ? rd_dm : '0, err: lat_dm > TO, at: done_at};
            done_q.push_back(d);
            t = done_at + 1;
        end
        if (do_if) begin
            a = '{dm: 1'b0, we: 1'b0, addr: if_addr, wdata: '0, be: '1,
                  lat: lat_if, rdata: rd_if, rise: t};
            mem_q.push_back(a);
            done_at = t + ((lat_if <= TO) ? lat_if : TO);
            d = '{dm: 1'b0, data: (lat_if <= TO) ? rd_if : '0, err: lat_if > TO, at: done_at};
            done_q.push_back(d);
        end
        i_dm_req   = do_dm;
        i_dm_we    = we;
        i_dm_addr  = dm_addr;
        i_dm_wdata = wdata;
        i_dm_be    = be;
        i_if_req   = do_if;
        i_if_addr  = if_addr;
        for (int n = 0; n < 2 * (TO + 3) + 8 && (i_if_req || i_dm_req); n++) begin
            @(negedge i_clk);
            if (o_dm_valid) begin
                i_dm_req   = 1'b0;
                i_dm_addr  = $urandom;
                i_dm_wdata = $urandom;
                i_dm_we    = 1'($urandom);
            end
            if (o_if_valid) begin
                i_if_req  = 1'b0;
                i_if_addr = $urandom;
            end
        end
        if (i_if_req || i_dm_req) begin
            check("round_complete", {i_dm_req, i_if_req}, 0);
            i_if_req = 1'b0;
            i_dm_req = 1'b0;
        end
        repeat ($urandom_range(1, 3)) @(negedge i_clk);
    endtask

    initial begin
        bit          rif, rdm;
        i_rst      = 1'b1;
        i_if_req   = 1'b1;
        i_dm_req   = 1'b1;
        i_dm_we    = 1'b1;
        i_if_addr  = 32'h1234_5678;
        i_dm_addr  = 32'h8765_4321;
        i_dm_wdata = 32'hFFFF_FFFF;
        i_dm_be    = '1;
        repeat (3) @(negedge i_clk);
        check("rst_mem_req", o_mem_req, 0);
        check("rst_mem_we", o_mem_we, 0);
        check("rst_mem_addr", o_mem_addr, 0);
        check("rst_mem_wdata", o_mem_wdata, 0);
        check("rst_mem_be", o_mem_be, 0);
        check("rst_if_data", o_if_data, 0);
        check("rst_dm_rdata", o_dm_rdata, 0);
        check("rst_if_valid", o_if_valid, 0);
        check("rst_dm_valid", o_dm_valid, 0);
        check("rst_err", o_err, 0);
        i_if_req = 1'b0;
        i_dm_req = 1'b0;
        i_rst    = 1'b0;
        resp_en  = 1'b1;
        repeat (2) @(negedge i_clk);

        run_round(1, 0, 0, 32'h100, '0, '0, '0, 3, 1, 32'h0000_0013, '0);
        run_round(1, 1, 0, 32'h3000, 32'h2000, '0, 4'hF, 1, 1, 32'h1111_2222, 32'hAAAA_5555);
        run_round(0, 1, 1, '0, 32'h40, 32'hDEAD_BEEF, 4'h3, 1, 2, '0, 32'h0BAD_F00D);
        run_round(1, 1, 0, 32'h700, 32'h800, '0, 4'hF, 2, TO + 1, 32'h7777_0000, 32'h5A5A_5A5A);
        run_round(1, 0, 0, 32'h900, '0, '0, '0, TO, 1, 32'h0000_CAFE, '0);
        run_round(0, 1, 0, '0, 32'hA00, '0, 4'hC, 1, TO, '0, 32'hFACE_0001);

        for (int i = 0; i < 120; i++) begin
            rdm = 1'($urandom);
            rif = rdm ? 1'($urandom) : 1'b1;
            run_round(rif, rdm, 1'($urandom), $urandom, $urandom, $urandom, 4'($urandom),
                      $urandom_range(1, TO + 2), $urandom_range(1, TO + 2), $urandom, $urandom);
        end

        // Reset in the second BUSY cycle, with an ack in and after the reset cycle.
        resp_en   = 1'b0;
        i_mem_ack = 1'b0;
        i_if_req  = 1'b1;
        i_if_addr = 32'h500;
        for (int n = 0; n < 4 && !o_mem_req; n++) @(negedge i_clk);
        check("rstbusy_req_up", o_mem_req, 1);
        @(negedge i_clk);
        i_rst       = 1'b1;
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'h1234_ABCD;
        @(negedge i_clk);
        check("rstbusy_req", o_mem_req, 0);
        check("rstbusy_if_valid", o_if_valid, 0);
        check("rstbusy_err", o_err, 0);
        i_rst    = 1'b0;
        i_if_req = 1'b0;
        @(negedge i_clk);
        i_mem_ack = 1'b0;
        check("rstbusy_after_req", o_mem_req, 0);
        check("rstbusy_after_valid", o_if_valid, 0);
        repeat (3) @(negedge i_clk);
        resp_en = 1'b1;
        @(negedge i_clk);
        run_round(1, 0, 0, 32'hB00, '0, '0, '0, 2, 1, 32'h0600_D000, '0);
        run_round(0, 1, 0, '0, 32'hC00, '0, 4'h1, 1, 1, '0, 32'h0000_0C00);

        repeat (4) @(negedge i_clk);
        check("mem_q_drained", mem_q.size(), 0);
        check("done_q_drained", done_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule
